// File: rtl/adc_scan_sequencer.sv
// Steps the analog mux across the phototransistor channels, converts each one,
// and publishes the darkest channel of every scan frame as the packed goalie word.
module adc_scan_sequencer #(
    parameter int NUM_CH         = 8,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int THRESHOLD      = 120
) (
    input  logic        CLK100MHZ,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  adc_data,
    input  logic        adc_valid,
    output logic [2:0]  mux_addr,
    output logic        adc_start,
    output logic        sample_valid,
    output logic [7:0]  sample_data,
    output logic [2:0]  sample_addr,
    output logic        frame_valid,
    output logic [7:0]  min_val,
    output logic [2:0]  min_addr,
    output logic [31:0] output_goalie,
    output logic        timeout_err,
    output logic        busy
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_CH      = 3'(NUM_CH - 1);
    localparam logic [7:0]    THRESH       = 8'(THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CONVERT = 3'd2,
        S_WAIT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          state_r, next_state_s;
    logic [SW-1:0]   settle_cnt_r;
    logic [TW-1:0]   wait_cnt_r;
    logic [2:0]      mux_addr_r, run_addr_r, upd_addr_s, sample_addr_r, min_addr_r;
    logic [7:0]      run_min_r, upd_min_s, sample_s, sample_data_r, min_val_r;
    logic [31:0]     goalie_r;
    logic            accept_s, lost_s, step_s;
    logic            adc_start_r, sample_valid_r, frame_valid_r, timeout_err_r, busy_r;

    // Next-state decode; a real adc_valid always beats a coincident timeout
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        lost_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (enable) begin
                    next_state_s = S_SETTLE;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    next_state_s = S_CONVERT;
                end else begin
                    next_state_s = S_SETTLE;
                end
            end
            S_CONVERT: next_state_s = S_WAIT;
            S_WAIT: begin
                if (adc_valid) begin
                    accept_s = 1'b1;
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    lost_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
                if (accept_s || lost_s) begin
                    next_state_s = (mux_addr_r == LAST_CH) ? S_DONE : S_SETTLE;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_DONE: begin
                if (enable) begin
                    next_state_s = S_SETTLE;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Running-minimum update; strict compare keeps the lowest channel on ties
    always_comb begin
        step_s     = accept_s | lost_s;
        sample_s   = lost_s ? 8'hFF : adc_data;
        upd_min_s  = run_min_r;
        upd_addr_s = run_addr_r;
        if (step_s && (sample_s < run_min_r)) begin
            upd_min_s  = sample_s;
            upd_addr_s = mux_addr_r;
        end else begin
            upd_min_s  = run_min_r;
            upd_addr_s = run_addr_r;
        end
    end

    // State register
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Counters, running minimum and registered outputs
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt_r   <= '0;
            wait_cnt_r     <= '0;
            mux_addr_r     <= 3'd0;
            run_min_r      <= 8'hFF;
            run_addr_r     <= 3'd0;
            adc_start_r    <= 1'b0;
            sample_valid_r <= 1'b0;
            sample_data_r  <= 8'd0;
            sample_addr_r  <= 3'd0;
            frame_valid_r  <= 1'b0;
            min_val_r      <= 8'hFF;
            min_addr_r     <= 3'd0;
            goalie_r       <= 32'd0;
            timeout_err_r  <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            settle_cnt_r   <= (state_r == S_SETTLE) ? settle_cnt_r + SW'(1'b1) : '0;
            wait_cnt_r     <= (state_r == S_WAIT) ? wait_cnt_r + TW'(1'b1) : '0;
            adc_start_r    <= (next_state_s == S_CONVERT);
            busy_r         <= (next_state_s != S_IDLE);
            sample_valid_r <= step_s;
            frame_valid_r  <= step_s && (next_state_s == S_DONE);
            if (lost_s) begin
                timeout_err_r <= 1'b1;
            end
            if (step_s) begin
                sample_data_r <= sample_s;
                sample_addr_r <= mux_addr_r;
            end
            if ((state_r == S_IDLE) || (state_r == S_DONE)) begin
                run_min_r  <= 8'hFF;
                run_addr_r <= 3'd0;
            end else if (step_s) begin
                run_min_r  <= upd_min_s;
                run_addr_r <= upd_addr_s;
            end
            if (state_r == S_DONE) begin
                mux_addr_r <= 3'd0;
            end else if (step_s && (mux_addr_r != LAST_CH)) begin
                mux_addr_r <= mux_addr_r + 3'd1;
            end
            // Publish on the last channel so the results are valid during DONE
            if (step_s && (next_state_s == S_DONE)) begin
                min_val_r  <= upd_min_s;
                min_addr_r <= upd_addr_s;
                goalie_r   <= {28'd0, upd_addr_s, (upd_min_s < THRESH)};
            end
        end
    end

    assign mux_addr      = mux_addr_r;
    assign adc_start     = adc_start_r;
    assign sample_valid  = sample_valid_r;
    assign sample_data   = sample_data_r;
    assign sample_addr   = sample_addr_r;
    assign frame_valid   = frame_valid_r;
    assign min_val       = min_val_r;
    assign min_addr      = min_addr_r;
    assign output_goalie = goalie_r;
    assign timeout_err   = timeout_err_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench: table of scan frames driven through an ADC model, with a
// per-sample scoreboard and hand-written enable-drop and mid-frame reset sequences.
module tb_adc_scan_sequencer;

    localparam int S = 4;
    localparam int T = 10;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset_n, enable, adc_valid;
    logic [7:0]  adc_data;
    logic [2:0]  mux_addr, sample_addr, min_addr;
    logic        adc_start, sample_valid, frame_valid, timeout_err, busy;
    logic [7:0]  sample_data, min_val;
    logic [31:0] output_goalie;

    always #5 clk = ~clk;

    adc_scan_sequencer #(
        .NUM_CH(N), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .THRESHOLD(120)
    ) dut (
        .CLK100MHZ(clk), .reset_n(reset_n), .enable(enable),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .mux_addr(mux_addr), .adc_start(adc_start),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_addr(sample_addr),
        .frame_valid(frame_valid), .min_val(min_val), .min_addr(min_addr),
        .output_goalie(output_goalie), .timeout_err(timeout_err), .busy(busy)
    );

    typedef struct {
        logic [7:0][7:0] data;
        int              dly;
        int              hold;
        bit              spur;
        int              lost;
        logic [7:0]      emin;
        logic [2:0]      eaddr;
        logic [31:0]     egoal;
        bit              eterr;
    } frame_t;

    frame_t      tbl [7];
    frame_t      cfg, f7, f8, f9;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ref_cyc = 0;
    logic [10:0] sb_q [$];
    logic [10:0] sb_exp;

    function automatic frame_t mk(input logic [7:0] c0, c1, c2, c3, c4, c5, c6, c7,
                                  input int dly, hold, input bit spur, input int lost,
                                  input logic [7:0] emin, input logic [2:0] eaddr,
                                  input logic [31:0] egoal, input bit eterr);
        frame_t f;
        f.data[0] = c0; f.data[1] = c1; f.data[2] = c2; f.data[3] = c3;
        f.data[4] = c4; f.data[5] = c5; f.data[6] = c6; f.data[7] = c7;
        f.dly = dly; f.hold = hold; f.spur = spur; f.lost = lost;
        f.emin = emin; f.eaddr = eaddr; f.egoal = egoal; f.eterr = eterr;
        return f;
    endfunction

    function automatic int frame_cycles(input frame_t f);
        int s = 0;
        for (int c = 0; c < N; c++) s += S + 1 + ((c == f.lost) ? T : f.dly);
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: answers each adc_start per the current frame config
    always begin : adc_model
        int         ch, dly, hold;
        bit         spur;
        logic [7:0] d;
        @(negedge clk);
        if (reset_n && adc_start) begin
            ch = int'(mux_addr);
            dly = cfg.dly; hold = cfg.hold; spur = cfg.spur; d = cfg.data[ch];
            if (ch == cfg.lost) begin
                sb_q.push_back({mux_addr, 8'hFF});
            end else begin
                sb_q.push_back({mux_addr, d});
                repeat (dly) @(negedge clk);
                adc_valid = 1'b1; adc_data = d;
                repeat (hold) @(negedge clk);
                adc_valid = 1'b0; adc_data = 8'h00;
                if (spur) begin
                    @(negedge clk); adc_valid = 1'b1;
                    @(negedge clk); adc_valid = 1'b0;
                end
            end
        end
    end

    // Sample scoreboard
    always @(negedge clk) begin
        if (sample_valid) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sample_extra: got addr %0d data %0h, expected no sample", sample_addr, sample_data);
            end else begin
                sb_exp = sb_q.pop_front();
                check("sample_addr", 32'(sample_addr), 32'(sb_exp[10:8]));
                check("sample_data", 32'(sample_data), 32'(sb_exp[7:0]));
            end
        end
    end

    task automatic wait_frame(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (frame_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL frame_wait: no frame_valid within %0d cycles", max_cyc);
        end
    endtask

    task automatic wait_mux(input logic [2:0] a, input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (mux_addr == a) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL mux_wait: mux_addr never reached %0d", a);
        end
    endtask

    task automatic check_frame(input string tag, input frame_t f);
        check({tag, "_min_val"},  32'(min_val), 32'(f.emin));
        check({tag, "_min_addr"}, 32'(min_addr), 32'(f.eaddr));
        check({tag, "_goalie"},   output_goalie, f.egoal);
        check({tag, "_timeout"},  32'(timeout_err), 32'(f.eterr));
        check({tag, "_busy"},     32'(busy), 32'd1);
        check({tag, "_latency"},  32'(cyc - ref_cyc), 32'(frame_cycles(f)));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mux_addr"},     32'(mux_addr), 32'd0);
        check({tag, "_adc_start"},    32'(adc_start), 32'd0);
        check({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_sample_data"},  32'(sample_data), 32'd0);
        check({tag, "_sample_addr"},  32'(sample_addr), 32'd0);
        check({tag, "_frame_valid"},  32'(frame_valid), 32'd0);
        check({tag, "_min_val"},      32'(min_val), 32'hFF);
        check({tag, "_min_addr"},     32'(min_addr), 32'd0);
        check({tag, "_goalie"},       output_goalie, 32'd0);
        check({tag, "_timeout"},      32'(timeout_err), 32'd0);
        check({tag, "_busy"},         32'(busy), 32'd0);
    endtask

    initial begin
        bit ok;
        int starts;
        // data c0..c7, delay, hold, spur, lost channel (8 = none), min, addr, goalie, timeout_err
        tbl[0] = mk(8'd200, 8'd180, 8'd90,  8'd150, 8'd130, 8'd140, 8'd160, 8'd170, 1, 1, 1'b1, 8, 8'd90,  3'd2, 32'h5, 1'b0);
        tbl[1] = mk(8'd120, 8'd120, 8'd120, 8'd120, 8'd120, 8'd120, 8'd120, 8'd120, 2, 3, 1'b0, 8, 8'd120, 3'd0, 32'h0, 1'b0);
        tbl[2] = mk(8'd40,  8'd70,  8'd60,  8'd30,  8'd90,  8'd30,  8'd200, 8'd210, T, 1, 1'b1, 8, 8'd30,  3'd3, 32'h7, 1'b0);
        tbl[3] = mk(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd119, 4, 2, 1'b0, 8, 8'd119, 3'd7, 32'hF, 1'b0);
        tbl[4] = mk(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1, 1, 1'b0, 8, 8'd255, 3'd0, 32'h0, 1'b0);
        tbl[5] = mk(8'd200, 8'd210, 8'd220, 8'd230, 8'd240, 8'd0,   8'd250, 8'd130, 1, 1, 1'b0, 5, 8'd130, 3'd7, 32'hE, 1'b1);
        tbl[6] = mk(8'd10,  8'd20,  8'd30,  8'd40,  8'd50,  8'd60,  8'd70,  8'd80,  1, 1, 1'b0, 8, 8'd10,  3'd0, 32'h1, 1'b1);
        f7     = mk(8'd90,  8'd80,  8'd70,  8'd200, 8'd200, 8'd200, 8'd200, 8'd75,  1, 1, 1'b0, 8, 8'd70,  3'd2, 32'h5, 1'b1);
        f8     = mk(8'd5,   8'd5,   8'd5,   8'd5,   8'd5,   8'd5,   8'd5,   8'd5,   1, 1, 1'b0, 8, 8'd5,   3'd0, 32'h1, 1'b1);
        f9     = mk(8'd100, 8'd110, 8'd120, 8'd130, 8'd140, 8'd150, 8'd160, 8'd170, 1, 1, 1'b0, 8, 8'd100, 3'd0, 32'h1, 1'b0);

        reset_n = 1'b0; enable = 1'b0; adc_valid = 1'b0; adc_data = 8'h00;
        cfg = tbl[0];
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset_n = 1'b1;
        @(negedge clk);

        enable = 1'b1;
        ref_cyc = cyc + 1;
        for (int i = 0; i < 7; i++) begin
            wait_frame(400, ok);
            if (ok) check_frame($sformatf("frame%0d", i), tbl[i]);
            ref_cyc = cyc + 1;
            cfg = (i < 6) ? tbl[i + 1] : f7;
            @(negedge clk);
            check($sformatf("frame%0d_fv_pulse", i), 32'(frame_valid), 32'd0);
            check($sformatf("frame%0d_hold", i), output_goalie, tbl[i].egoal);
        end

        // Enable dropped mid-frame: the frame still completes, then IDLE
        wait_mux(3'd3, 200);
        enable = 1'b0;
        wait_frame(400, ok);
        if (ok) check_frame("endrop", f7);
        @(negedge clk);
        check("endrop_busy", 32'(busy), 32'd0);
        check("endrop_mux", 32'(mux_addr), 32'd0);
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (adc_start) starts++;
        end
        check("endrop_idle_starts", 32'(starts), 32'd0);
        check("endrop_hold", output_goalie, 32'h5);

        // Reset at channel 6, then a clean frame after release
        cfg = f8;
        enable = 1'b1;
        wait_mux(3'd6, 400);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (4) @(negedge clk);
        sb_q.delete();
        cfg = f9;
        reset_n = 1'b1;
        ref_cyc = cyc + 1;
        wait_frame(400, ok);
        if (ok) check_frame("postrst", f9);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("postrst_busy", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
